mm_job_arbiter: RTL and testbench

- Round-robin arbiter that shares one 3x3 matrix-multiply engine (the existing 8-bit-in / 16-bit-out multiply top, with a start/done interface) among NREQ requesters.
- For each job it grants one requester, captures that requester's A/B operands, pulses the engine start, and waits for the engine done pulse or a timeout.
- It then returns the 3x3 result, tagged with the requester id, over a valid/ready response port.
- It sits between the client blocks and the single multiply engine instance.

---
 rtl/mm_job_arbiter.sv | 140 ++++++++++++++
 tb/tb_mm_job_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_job_arbiter.sv
// Round-robin arbiter sharing one 3x3 matrix-multiply engine among NREQ requesters.
// Latency: gnt/eng_start one cycle after req is sampled in IDLE; response one cycle after eng_done or TIMEOUT WAIT cycles.
// Backpressure: response held until rsp_ready; no new grant until the response is accepted and IDLE is re-entered.
module mm_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*72-1:0]   a_in,
    input  logic [NREQ*72-1:0]   b_in,
    output logic [NREQ-1:0]      gnt,
    output logic                 eng_start,
    output logic [71:0]          eng_a,
    output logic [71:0]          eng_b,
    input  logic                 eng_done,
    input  logic [143:0]         eng_c,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [143:0]         rsp_c,
    output logic                 rsp_err,
    output logic                 busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);
    localparam logic [NREQ-1:0]  GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  owner;
    logic [CNT_W-1:0] cnt;

    logic             hi_vld;
    logic [ID_W-1:0]  hi_id;
    logic [ID_W-1:0]  lo_id;
    logic [ID_W-1:0]  win_id;
    logic [71:0]      win_a;
    logic [71:0]      win_b;

    // Round-robin pick: lowest requester at or above the pointer, else wrap to the lowest requester overall.
    always_comb begin
        hi_vld = 1'b0;
        hi_id  = '0;
        lo_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_id = ID_W'(i);
                if (ID_W'(i) >= ptr) begin
                    hi_vld = 1'b1;
                    hi_id  = ID_W'(i);
                end
            end
        end
        win_id = hi_vld ? hi_id : lo_id;
    end

    // Select the winning requester's operand slices.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_a = a_in[i*72 +: 72];
                win_b = b_in[i*72 +: 72];
            end
        end
    end

    // Job sequencing: grant and capture in IDLE, wait for done or timeout, hold the response until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            gnt       <= '0;
            eng_start <= 1'b0;
            eng_a     <= '0;
            eng_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt       <= '0;
            eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt       <= GNT_ONE << win_id;
                        eng_start <= 1'b1;
                        eng_a     <= win_a;
                        eng_b     <= win_b;
                        owner     <= win_id;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Done has priority over the timeout on the same edge.
                    if (eng_done) begin
                        rsp_c     <= eng_c;
                        rsp_err   <= 1'b0;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_c     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        ptr       <= (owner == LAST_ID) ? '0 : owner + ID_W'(1);
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mm_job_arbiter.sv
// Randomized scoreboard bench for mm_job_arbiter with a behavioural engine and arbitration model.
// Latency: engine answers a configurable number of cycles after eng_start (0 = never).
// Backpressure: rsp_ready is driven low in directed and random phases.
module tb_mm_job_arbiter;
    localparam int NREQ    = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*72-1:0]  a_in;
    logic [NREQ*72-1:0]  b_in;
    logic [NREQ-1:0]     gnt;
    logic                eng_start;
    logic [71:0]         eng_a;
    logic [71:0]         eng_b;
    logic                eng_done;
    logic [143:0]        eng_c;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [143:0]        rsp_c;
    logic                rsp_err;
    logic                busy;

    logic [71:0] op_a [NREQ];
    logic [71:0] op_b [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign a_in[g*72 +: 72] = op_a[g];
        assign b_in[g*72 +: 72] = op_b[g];
    end

    mm_job_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done), .eng_c(eng_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stimulus-side controls
    int              eng_delay;
    logic [NREQ-1:0] hold_mask;
    bit              rand_mode;
    bit              stall_err;

    // Scoreboard state
    typedef struct {
        int           id;
        logic [143:0] c;
        logic         err;
        int           rise;
    } exp_t;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   model_ptr = 0;
    bit   model_busy = 0;
    bit   stall_rep = 0;
    logic            p_rst = 1'b1;
    logic            p_hs = 1'b0;
    logic [NREQ-1:0] p_req = '0;
    logic [71:0]     p_op_a [NREQ];
    logic [71:0]     p_op_b [NREQ];

    function automatic logic [143:0] matmul(logic [71:0] a, logic [71:0] b);
        int av [3][3];
        int bv [3][3];
        int s;
        logic [143:0] c;
        c = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                av[i][j] = int'(a[71 - 8*(3*i+j) -: 8]);
                bv[i][j] = int'(b[71 - 8*(3*i+j) -: 8]);
            end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) s += av[i][k] * bv[k][j];
                c[143 - 16*(3*i+j) -: 16] = 16'(s);
            end
        return c;
    endfunction

    function automatic int pick_winner(logic [NREQ-1:0] r, int ptr);
        for (int i = 0; i < NREQ; i++)
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [143:0] rnd144();
        return 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    function automatic void check(string name, logic [319:0] act, logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Behavioural engine: done pulse eng_delay cycles after start with the product; garbage on eng_c otherwise.
    initial begin : engine
        int d;
        logic [143:0] c;
        eng_done = 1'b0;
        eng_c    = rnd144();
        forever begin
            @(posedge clk); #1;
            eng_c = rnd144();
            if (eng_start) begin
                d = eng_delay;
                c = matmul(eng_a, eng_b);
                if (d > 0) begin
                    repeat (d - 1) begin
                        @(posedge clk); #1;
                        eng_c = rnd144();
                    end
                    eng_done = 1'b1;
                    eng_c    = c;
                    @(posedge clk); #1;
                    eng_done = 1'b0;
                    eng_c    = rnd144();
                end
            end
        end
    end

    // Monitor: at each falling edge, model the rising edge just taken and compare the DUT outputs.
    always @(negedge clk) begin : monitor
        bit   idle_before;
        bit   exp_g;
        bit   exp_v;
        int   w;
        int   lat;
        bit   terr;
        exp_t e;
        cyc++;
        if (p_rst) begin
            sb.delete();
            model_busy = 0;
            model_ptr  = 0;
            check("reset_state", {gnt, eng_start, eng_a, eng_b, rsp_valid, rsp_id, rsp_c, rsp_err, busy}, '0);
        end else begin
            idle_before = !model_busy;
            if (p_hs) begin
                check("rsp_job_pending", 320'(sb.size() != 0), 320'(1));
                if (sb.size() != 0) begin
                    e          = sb.pop_front();
                    model_ptr  = (e.id + 1) % NREQ;
                    model_busy = 0;
                end
            end
            exp_g = idle_before && (p_req != 0);
            if (exp_g || gnt != 0 || eng_start) begin
                w = exp_g ? pick_winner(p_req, model_ptr) : 0;
                check("gnt", 320'(gnt), exp_g ? 320'(1 << w) : 320'(0));
                check("eng_start", 320'(eng_start), 320'(exp_g));
                if (exp_g) begin
                    check("eng_a", 320'(eng_a), 320'(p_op_a[w]));
                    check("eng_b", 320'(eng_b), 320'(p_op_b[w]));
                    terr   = (eng_delay == 0) || (eng_delay > TIMEOUT);
                    lat    = terr ? TIMEOUT : eng_delay;
                    e.id   = w;
                    e.err  = terr;
                    e.c    = terr ? '0 : matmul(p_op_a[w], p_op_b[w]);
                    e.rise = cyc + lat;
                    sb.push_back(e);
                    model_busy = 1;
                end
            end
            exp_v = (sb.size() != 0) && (cyc >= sb[0].rise);
            if (exp_v || rsp_valid || model_busy)
                check("rsp_valid", 320'(rsp_valid), 320'(exp_v));
            if (exp_v && rsp_valid) begin
                check("rsp_id", 320'(rsp_id), 320'(sb[0].id));
                check("rsp_c", 320'(rsp_c), 320'(sb[0].c));
                check("rsp_err", 320'(rsp_err), 320'(sb[0].err));
            end
            check("busy", 320'(busy), 320'(model_busy));
        end
        if (stall_err && !stall_rep) begin
            stall_rep = 1;
            check("wait_bound_expired", 320'(stall_err), 320'(0));
        end
        p_rst  = rst;
        p_req  = req;
        p_hs   = rsp_valid && rsp_ready;
        p_op_a = op_a;
        p_op_b = op_b;
    end

    function automatic int pick_delay();
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return TIMEOUT;
            2:       return TIMEOUT + 1;
            default: return int'($urandom_range(1, 8));
        endcase
    endfunction

    task automatic load(int r);
        op_a[r] = 72'({$urandom(), $urandom(), $urandom()});
        op_b[r] = 72'({$urandom(), $urandom(), $urandom()});
        req[r]  = 1'b1;
    endtask

    // One clock: granted requesters withdraw, then held/random requesters act.
    task automatic tick();
        @(posedge clk); #1;
        req = req & ~gnt;
        if (rand_mode) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (busy && gnt == 0) eng_delay = pick_delay();
            for (int r = 0; r < NREQ; r++) begin
                if (!req[r] && $urandom_range(0, 7) == 0) load(r);
                else if (req[r] && $urandom_range(0, 63) == 0) req[r] = 1'b0;
            end
        end
        for (int r = 0; r < NREQ; r++)
            if (hold_mask[r] && !req[r]) load(r);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((req != 0 || busy || rsp_valid) && n < 3000);
        if (n >= 3000) stall_err = 1;
    endtask

    initial begin : stim
        int n;
        int g;
        rst       = 1'b1;
        req       = '0;
        rsp_ready = 1'b1;
        eng_delay = 5;
        hold_mask = '0;
        rand_mode = 0;
        stall_err = 0;
        for (int r = 0; r < NREQ; r++) begin
            op_a[r] = '0;
            op_b[r] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic job: identity x [1..9]
        op_a[0] = 72'h01_00_00_00_01_00_00_00_01;
        op_b[0] = 72'h01_02_03_04_05_06_07_08_09;
        req[0]  = 1'b1;
        wait_idle();

        // Round robin with all requesters held, then a sparse pattern
        hold_mask = '1;
        g = 0;
        n = 0;
        while (g < 5 && n < 2000) begin
            tick();
            if (gnt != 0) g++;
            n++;
        end
        if (n >= 2000) stall_err = 1;
        hold_mask = '0;
        wait_idle();
        load(1);
        wait_idle();
        load(1);
        load(3);
        wait_idle();

        // Timeout, done on the timeout cycle, and a done arriving one cycle too late
        eng_delay = 0;
        load(2);
        wait_idle();
        eng_delay = TIMEOUT;
        load(1);
        wait_idle();
        eng_delay = TIMEOUT + 1;
        load(0);
        wait_idle();

        // Backpressure with a pending request
        eng_delay = 5;
        rsp_ready = 1'b0;
        load(0);
        tick();
        load(2);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) stall_err = 1;
        repeat (10) tick();
        rsp_ready = 1'b1;
        wait_idle();

        // Reset in the middle of WAIT; the stale done must be ignored
        eng_delay = 5;
        load(2);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 0 && n < 50);
        if (n >= 50) stall_err = 1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        for (int r = 0; r < NREQ; r++) load(r);
        wait_idle();

        // Randomized traffic
        rand_mode = 1;
        repeat (3000) tick();
        rand_mode = 0;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule
